// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : seg_pkg
//  Purpose : Shared definitions for the seven-segment scan driver: field
//            positions inside the 12-bit logical display word, the word type
//            and the hex-digit to abcdefg encoding table.
//  Ports   : (package - no ports)
//  Revision: 1.0 - initial release
// ============================================================================
package seg_pkg;

   // Logical word layout: [11:8] = SEL3..SEL0, [7:1] = A..G, [0] = DP
   localparam int SEL_MSB = 11;
   localparam int SEL_LSB = 8;
   localparam int SEG_A   = 7;
   localparam int SEG_B   = 6;
   localparam int SEG_C   = 5;
   localparam int SEG_D   = 4;
   localparam int SEG_E   = 3;
   localparam int SEG_F   = 2;
   localparam int SEG_G   = 1;
   localparam int SEG_DP  = 0;

   typedef logic [11:0] seg_word_t;

   // Active-high abcdefg pattern for one hex digit (bit 6 = a, bit 0 = g).
   function automatic logic [6:0] hex7(input logic [3:0] nibble);
      logic [6:0] segs;
      case (nibble)
         4'h0:    segs = 7'b1111110;
         4'h1:    segs = 7'b0110000;
         4'h2:    segs = 7'b1101101;
         4'h3:    segs = 7'b1111001;
         4'h4:    segs = 7'b0110011;
         4'h5:    segs = 7'b1011011;
         4'h6:    segs = 7'b1011111;
         4'h7:    segs = 7'b1110000;
         4'h8:    segs = 7'b1111111;
         4'h9:    segs = 7'b1111011;
         4'hA:    segs = 7'b1110111;
         4'hB:    segs = 7'b0011111;
         4'hC:    segs = 7'b1001110;
         4'hD:    segs = 7'b0111101;
         4'hE:    segs = 7'b1001111;
         default: segs = 7'b1000111;
      endcase
      return segs;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seg_hex7.sv
`default_nettype none
// ============================================================================
//  Module  : seg_hex7
//  Purpose : Pure combinational hex nibble to seven-segment (abcdefg) encoder.
//            Output is active-high; polarity is applied by the caller.
//  Ports   : nibble  in  4  hex digit to encode
//            segs    out 7  {a,b,c,d,e,f,g}, 1 = segment lit
//  Revision: 1.0 - initial release
// ============================================================================
module seg_hex7
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] segs
);

   assign segs = hex7(nibble);

endmodule
`default_nettype wire

// File: rtl/seg_scan.sv
`default_nettype none
// ============================================================================
//  Module  : seg_scan
//  Purpose : Time-multiplexed driver for a 4-digit seven-segment display.
//            Accepts a 16-bit hex value plus decimal points over valid/ready,
//            buffers it until the next frame boundary, and scans the digits
//            producing the logical word [SEL3..SEL0, A..G, DP].
//  Ports   : clk          in  1   system clock
//            rst          in  1   asynchronous reset, active-high
//            en           in  1   display enable (low -> inactive word)
//            load_valid   in  1   new display value offered
//            load_ready   out 1   pending buffer empty
//            load_value   in  16  four hex digits, [3:0] = digit 0
//            load_dp      in  4   decimal points, bit k = digit k
//            frame_start  out 1   pulse when scan wraps digit 3 -> 0
//            out          out 12  [11:8] SEL3..SEL0, [7:1] A..G, [0] DP
//  Revision: 1.0 - initial release
// ============================================================================
module seg_scan
   import seg_pkg::*;
#(
   parameter int CLK_DIV        = 1000,
   parameter int BLANK_CYCLES   = 1,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit SEL_ACTIVE_LOW = 1'b1
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        load_valid,
   output logic        load_ready,
   input  logic [15:0] load_value,
   input  logic [3:0]  load_dp,
   output logic        frame_start,
   output seg_word_t   out
);

   localparam int            CNT_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
   localparam logic [3:0]    SEL_OFF   = SEL_ACTIVE_LOW ? 4'hF : 4'h0;
   localparam logic [7:0]    SEG_OFF   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
   localparam seg_word_t     IDLE_WORD = {SEL_OFF, SEG_OFF};

   logic [CNT_W-1:0] cnt;
   logic [1:0]       idx;
   logic [15:0]      active_value;
   logic [3:0]       active_dp;
   logic [15:0]      pending_value;
   logic [3:0]       pending_dp;
   logic             pending_valid;

   logic             slot_end;
   logic             frame_end;
   logic             accept;
   logic [3:0]       nibble;
   logic [6:0]       segs;
   logic [3:0]       sel_on;
   seg_word_t        next_word;

   assign slot_end   = (cnt == CNT_MAX);
   assign frame_end  = slot_end && (idx == 2'd3);
   assign load_ready = !pending_valid;
   assign accept     = load_valid && !pending_valid;

   // ------------------------------------------------------------------
   // Slot counter, digit index and frame pulse. The scan free-runs so
   // that toggling en never disturbs the digit phase.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt         <= '0;
         idx         <= 2'd0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= frame_end;
         if (slot_end) begin
            cnt <= '0;
            idx <= idx + 2'd1;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Load buffering. A value only reaches the active registers on a frame
   // boundary, so a frame always shows one consistent value. An accept
   // needs an empty pending slot, so accept and promotion never collide
   // on the same register in one cycle.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_value  <= 16'h0000;
         active_dp     <= 4'h0;
         pending_value <= 16'h0000;
         pending_dp    <= 4'h0;
         pending_valid <= 1'b0;
      end else begin
         if (frame_end && pending_valid) begin
            active_value  <= pending_value;
            active_dp     <= pending_dp;
            pending_valid <= 1'b0;
         end
         if (accept) begin
            pending_value <= load_value;
            pending_dp    <= load_dp;
            pending_valid <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Output word for the current (cnt, idx), registered below.
   // ------------------------------------------------------------------
   assign nibble = active_value[{idx, 2'b00} +: 4];
   assign sel_on = 4'b0001 << idx;

   seg_hex7 u_hex7 (
      .nibble (nibble),
      .segs   (segs)
   );

   always_comb begin
      next_word = IDLE_WORD;
      // Leading cycles of each slot stay dark so the previous digit's
      // segments never flash on the newly selected digit.
      if (en && !(cnt < BLANK_END)) begin
         next_word[SEL_MSB:SEL_LSB] = SEL_ACTIVE_LOW ? ~sel_on : sel_on;
         next_word[SEG_A]  = segs[6] ^ SEG_ACTIVE_LOW;
         next_word[SEG_B]  = segs[5] ^ SEG_ACTIVE_LOW;
         next_word[SEG_C]  = segs[4] ^ SEG_ACTIVE_LOW;
         next_word[SEG_D]  = segs[3] ^ SEG_ACTIVE_LOW;
         next_word[SEG_E]  = segs[2] ^ SEG_ACTIVE_LOW;
         next_word[SEG_F]  = segs[1] ^ SEG_ACTIVE_LOW;
         next_word[SEG_G]  = segs[0] ^ SEG_ACTIVE_LOW;
         next_word[SEG_DP] = active_dp[idx] ^ SEG_ACTIVE_LOW;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out <= IDLE_WORD;
      end else begin
         out <= next_word;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : tb_seg_scan
//  Purpose : Directed self-checking bench for seg_scan (CLK_DIV = 4,
//            BLANK_CYCLES = 1, active-low segments and selects).
//            Within a frame, position k (1..16) counts negedges after the
//            negedge where frame_start is seen; slot s occupies k = 4s+1
//            (blank) and k = 4s+2..4s+4 (data), frame_start at k = 16.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_seg_scan;

   localparam logic [11:0] IDLE = 12'hFFF;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        load_valid;
   logic        load_ready;
   logic [15:0] load_value;
   logic [3:0]  load_dp;
   logic        frame_start;
   logic [11:0] out;

   int checks = 0;
   int fails  = 0;

   logic [11:0] cap_out [1:16];
   logic        cap_fs  [1:16];

   seg_scan #(
      .CLK_DIV        (4),
      .BLANK_CYCLES   (1),
      .SEG_ACTIVE_LOW (1'b1),
      .SEL_ACTIVE_LOW (1'b1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .load_value  (load_value),
      .load_dp     (load_dp),
      .frame_start (frame_start),
      .out         (out)
   );

   always #5 clk = ~clk;

   // Advance to the next negedge at which frame_start is high (k = 0).
   task automatic wait_frame(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_start && n < 40);
      checks++;
      if (frame_start !== 1'b1) begin
         fails++;
         $display("FAIL %s frame_start timeout: got %b after %0d cycles, expected 1", name, frame_start, n);
      end
   endtask

   // Record out/frame_start at positions start..16; called at position start-1.
   task automatic grab_frame(input int start);
      for (int k = start; k <= 16; k++) begin
         @(negedge clk);
         cap_out[k] = out;
         cap_fs[k]  = frame_start;
      end
   endtask

   task automatic test_reset();
      logic [11:0] w [0:3];
      w = '{12'hE03, 12'hD03, 12'hB03, 12'h703};
      rst = 1'b1; en = 1'b1; load_valid = 1'b0; load_value = 16'h0; load_dp = 4'h0;
      #1;
      checks++; if (out !== IDLE) begin fails++; $display("FAIL reset_out got %h expected %h", out, IDLE); end
      checks++; if (load_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b expected 1", load_ready); end
      checks++; if (frame_start !== 1'b0) begin fails++; $display("FAIL reset_fs got %b expected 0", frame_start); end
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      // mid-scan reset with a pending load
      wait_frame("rst_sync");
      repeat (3) @(negedge clk);
      load_value = 16'hABCD; load_dp = 4'hF; load_valid = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      checks++; if (load_ready !== 1'b0) begin fails++; $display("FAIL rst_pending_ready got %b expected 0", load_ready); end
      #2 rst = 1'b1;
      #1;
      checks++; if (out !== IDLE) begin fails++; $display("FAIL rst_async_out got %h expected %h", out, IDLE); end
      checks++; if (load_ready !== 1'b1) begin fails++; $display("FAIL rst_async_ready got %b expected 1", load_ready); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (out !== IDLE) begin fails++; $display("FAIL rst_first_blank got %h expected %h", out, IDLE); end
      @(negedge clk);
      checks++; if (out !== 12'hE03) begin fails++; $display("FAIL rst_first_digit got %h expected e03", out); end
      checks++; if (load_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready got %b expected 1", load_ready); end
      // pending ABCD was discarded: the whole next frame shows 0000
      wait_frame("rst_frame");
      grab_frame(1);
      for (int k = 1; k <= 16; k++) begin
         checks++;
         if (cap_out[k] !== (((k-1)%4 == 0) ? IDLE : w[(k-1)/4])) begin
            fails++;
            $display("FAIL rst_frame k=%0d got %h expected %h", k, cap_out[k], (((k-1)%4 == 0) ? IDLE : w[(k-1)/4]));
         end
         checks++;
         if (cap_fs[k] !== (k == 16)) begin fails++; $display("FAIL rst_frame_fs k=%0d got %b expected %b", k, cap_fs[k], (k == 16)); end
      end
   endtask

   task automatic test_load_update();
      logic [11:0] old_w [0:3];
      logic [11:0] new_w [0:3];
      old_w = '{12'hE03, 12'hD03, 12'hB03, 12'h703};
      new_w = '{12'hE99, 12'hD0D, 12'hB25, 12'h79F};
      wait_frame("load_sync");
      load_value = 16'h1234; load_dp = 4'h0; load_valid = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      checks++; if (load_ready !== 1'b0) begin fails++; $display("FAIL load_ready_drop got %b expected 0", load_ready); end
      grab_frame(2);
      for (int k = 2; k <= 16; k++) begin
         checks++;
         if (cap_out[k] !== (((k-1)%4 == 0) ? IDLE : old_w[(k-1)/4])) begin
            fails++;
            $display("FAIL load_old_frame k=%0d got %h expected %h", k, cap_out[k], (((k-1)%4 == 0) ? IDLE : old_w[(k-1)/4]));
         end
      end
      checks++; if (cap_fs[16] !== 1'b1) begin fails++; $display("FAIL load_fs got %b expected 1", cap_fs[16]); end
      checks++; if (load_ready !== 1'b1) begin fails++; $display("FAIL load_ready_rise got %b expected 1", load_ready); end
      grab_frame(1);
      for (int k = 1; k <= 16; k++) begin
         checks++;
         if (cap_out[k] !== (((k-1)%4 == 0) ? IDLE : new_w[(k-1)/4])) begin
            fails++;
            $display("FAIL load_new_frame k=%0d got %h expected %h", k, cap_out[k], (((k-1)%4 == 0) ? IDLE : new_w[(k-1)/4]));
         end
      end
   endtask

   task automatic test_frame_period();
      int n;
      wait_frame("period_sync");
      for (int f = 0; f < 2; f++) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!frame_start && n < 40);
         checks++;
         if (n !== 16) begin fails++; $display("FAIL frame_period got %0d cycles expected 16", n); end
      end
   endtask

   task automatic test_back_to_back();
      logic [11:0] w1 [0:3];
      logic [11:0] w2 [0:3];
      w1 = '{12'hE01, 12'hD1F, 12'hB41, 12'h749};
      w2 = '{12'hE03, 12'hD02, 12'hB03, 12'h703};
      wait_frame("b2b_sync");
      load_value = 16'h5678; load_dp = 4'h0; load_valid = 1'b1;
      @(negedge clk);
      checks++; if (load_ready !== 1'b0) begin fails++; $display("FAIL b2b_first_accept ready got %b expected 0", load_ready); end
      // second offer held while the first waits for the boundary
      load_value = 16'h0000; load_dp = 4'b0010;
      for (int k = 2; k <= 15; k++) begin
         @(negedge clk);
         checks++;
         if (load_ready !== 1'b0) begin fails++; $display("FAIL b2b_hold k=%0d ready got %b expected 0", k, load_ready); end
      end
      @(negedge clk);
      checks++; if (frame_start !== 1'b1) begin fails++; $display("FAIL b2b_fs got %b expected 1", frame_start); end
      checks++; if (load_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_rise got %b expected 1", load_ready); end
      @(negedge clk);
      load_valid = 1'b0;
      checks++; if (load_ready !== 1'b0) begin fails++; $display("FAIL b2b_second_accept ready got %b expected 0", load_ready); end
      checks++; if (out !== IDLE) begin fails++; $display("FAIL b2b_blank got %h expected %h", out, IDLE); end
      grab_frame(2);
      for (int k = 2; k <= 16; k++) begin
         checks++;
         if (cap_out[k] !== (((k-1)%4 == 0) ? IDLE : w1[(k-1)/4])) begin
            fails++;
            $display("FAIL b2b_frame1 k=%0d got %h expected %h", k, cap_out[k], (((k-1)%4 == 0) ? IDLE : w1[(k-1)/4]));
         end
      end
      grab_frame(1);
      for (int k = 1; k <= 16; k++) begin
         checks++;
         if (cap_out[k] !== (((k-1)%4 == 0) ? IDLE : w2[(k-1)/4])) begin
            fails++;
            $display("FAIL b2b_frame2 k=%0d got %h expected %h", k, cap_out[k], (((k-1)%4 == 0) ? IDLE : w2[(k-1)/4]));
         end
      end
   endtask

   task automatic test_dp();
      logic [11:0] w [0:3];
      w = '{12'hE02, 12'hD03, 12'hB03, 12'h702};
      // caller leaves us at k = 0 of a frame showing 0000 / dp 0010
      load_value = 16'h0000; load_dp = 4'b1001; load_valid = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      grab_frame(2);
      checks++; if (cap_out[8] !== 12'hD02) begin fails++; $display("FAIL dp_old_slot1 got %h expected d02", cap_out[8]); end
      grab_frame(1);
      for (int k = 1; k <= 16; k++) begin
         checks++;
         if (cap_out[k] !== (((k-1)%4 == 0) ? IDLE : w[(k-1)/4])) begin
            fails++;
            $display("FAIL dp_frame k=%0d got %h expected %h", k, cap_out[k], (((k-1)%4 == 0) ? IDLE : w[(k-1)/4]));
         end
      end
   endtask

   task automatic test_enable();
      logic [11:0] w [0:3];
      logic [11:0] exp_out;
      w = '{12'hE02, 12'hD03, 12'hB03, 12'h702};
      wait_frame("en_sync");
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (k >= 6 && k <= 15) exp_out = IDLE;
         else exp_out = ((k-1)%4 == 0) ? IDLE : w[(k-1)/4];
         checks++;
         if (out !== exp_out) begin fails++; $display("FAIL en_frame k=%0d got %h expected %h", k, out, exp_out); end
         checks++;
         if (frame_start !== (k == 16)) begin fails++; $display("FAIL en_fs k=%0d got %b expected %b", k, frame_start, (k == 16)); end
         if (k == 5)  en = 1'b0;
         if (k == 15) en = 1'b1;
      end
      grab_frame(1);
      for (int k = 1; k <= 16; k++) begin
         checks++;
         if (cap_out[k] !== (((k-1)%4 == 0) ? IDLE : w[(k-1)/4])) begin
            fails++;
            $display("FAIL en_resume k=%0d got %h expected %h", k, cap_out[k], (((k-1)%4 == 0) ? IDLE : w[(k-1)/4]));
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_update();
      test_frame_period();
      test_back_to_back();
      test_dp();
      test_enable();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
`default_nettype wire
